// File: rtl/rs_int_pkg.sv
// rs_int_pkg: shared sizing and packet types for the integer reservation station
package rs_int_pkg;
  localparam int NUM_ENTRIES = 8;
  localparam int RS_ID_W = $clog2(NUM_ENTRIES);
  localparam int ROBID_W = 6;
  localparam int PREG_W = 6;
  localparam int DATA_W = 32;
  typedef logic [RS_ID_W-1:0] t_rs_id;
  typedef enum logic [1:0] {OP_REG, OP_IMM, OP_PC} t_optype;
  typedef struct packed {
    logic [7:0] opc;
    t_optype    src2_type;
  } t_uinstr;
  typedef struct packed {
    t_uinstr             uinstr;
    logic [ROBID_W-1:0]  robid;
    logic [PREG_W-1:0]   pdst;
    logic [PREG_W-1:0]   psrc1;
    logic [PREG_W-1:0]   psrc2;
    logic                src1_rdy;
    logic                src2_rdy;
    logic [DATA_W-1:0]   src1_val;
    logic [DATA_W-1:0]   src2_val;
  } t_rs_disp_pkt;
  typedef struct packed {
    t_uinstr             uinstr;
    logic [ROBID_W-1:0]  robid;
    logic [PREG_W-1:0]   pdst;
    logic [DATA_W-1:0]   src1_val;
    logic [DATA_W-1:0]   src2_val;
  } t_iss_pkt;
  typedef struct packed {
    logic [PREG_W-1:0] pdst;
    logic [DATA_W-1:0] data;
  } t_prf_wr_pkt;
  typedef struct packed {
    logic valid;
  } t_nuke_pkt;
endpackage

// File: rtl/rs_int_if.sv
// rs_int_if: dispatch, write-back wakeup and issue signals of the integer RS
interface rs_int_if;
  import rs_int_pkg::*;
  t_nuke_pkt          nuke_rb1;
  logic               disp_valid_rs0;
  t_rs_disp_pkt       disp_pkt_rs0;
  logic               disp_rdy_rs0;
  logic               iprf_wr_en_ex1;
  t_prf_wr_pkt        iprf_wr_pkt_ex1;
  logic               iss_ex0;
  t_iss_pkt           iss_pkt_ex0;
  logic [RS_ID_W:0]   rs_occ;
  modport master (
    output nuke_rb1, disp_valid_rs0, disp_pkt_rs0, iprf_wr_en_ex1, iprf_wr_pkt_ex1,
    input  disp_rdy_rs0, iss_ex0, iss_pkt_ex0, rs_occ
  );
  modport slave (
    input  nuke_rb1, disp_valid_rs0, disp_pkt_rs0, iprf_wr_en_ex1, iprf_wr_pkt_ex1,
    output disp_rdy_rs0, iss_ex0, iss_pkt_ex0, rs_occ
  );
endinterface

// File: rtl/rs_int_age.sv
// rs_int_age: age matrix picking the oldest ready entry
module rs_int_age
  import rs_int_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_ENTRIES-1:0] alloc_i,
  input  logic [NUM_ENTRIES-1:0] free_i,
  input  logic [NUM_ENTRIES-1:0] ready_i,
  output logic [NUM_ENTRIES-1:0] oldest_o
);
  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] col [NUM_ENTRIES];
  // Row i bit j: entry i older than j; a new entry is younger than everyone, frees clear the column
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        older_d[i][j] = alloc_i[i] ? 1'b0 : alloc_i[j] ? (i != j) : free_i[j] ? 1'b0 : older_q[i][j];
        col[j][i] = older_q[i][j];
      end
    end
  end
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_old
    assign oldest_o[g] = ready_i[g] & ~|(ready_i & col[g]);
  end
  // Matrix state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) for (int i = 0; i < NUM_ENTRIES; i++) older_q[i] <= '0;
    else for (int i = 0; i < NUM_ENTRIES; i++) older_q[i] <= older_d[i];
  end
endmodule

// File: rtl/rs_int.sv
// rs_int: integer reservation station feeding the single execute pipe
module rs_int
  import rs_int_pkg::*;
(
  input logic     clk,
  input logic     reset_n,
  rs_int_if.slave rs
);
  logic                   nuke, disp_rdy, acc, iss_q;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d, ready, alloc, sel;
  logic [RS_ID_W:0]       occ_q, occ_d;
  t_rs_disp_pkt           ent_q [NUM_ENTRIES];
  t_rs_disp_pkt           ent_d [NUM_ENTRIES];
  t_rs_disp_pkt           disp_e;
  t_iss_pkt               pkt_q, pkt_d;
  t_prf_wr_pkt            wb;
  assign nuke = rs.nuke_rb1.valid;
  assign wb = rs.iprf_wr_pkt_ex1;
  assign disp_rdy = occ_q < (RS_ID_W+1)'(NUM_ENTRIES);
  assign acc = rs.disp_valid_rs0 & disp_rdy & ~nuke;
  assign alloc = acc ? ~valid_q & (valid_q + 1'b1) : '0;
  assign occ_d = nuke ? '0 : occ_q + (RS_ID_W+1)'(acc) - (RS_ID_W+1)'(|sel);
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_rdy
    assign ready[g] = valid_q[g] & ent_q[g].src1_rdy & ent_q[g].src2_rdy & ~nuke;
  end
  rs_int_age u_age (
    .clk      (clk),
    .reset_n  (reset_n),
    .alloc_i  (alloc),
    .free_i   (sel),
    .ready_i  (ready),
    .oldest_o (sel)
  );
  // Dispatched uop: immediates are ready as zero, a same-cycle write-back is captured
  always_comb begin
    disp_e = rs.disp_pkt_rs0;
    if (!disp_e.src1_rdy && rs.iprf_wr_en_ex1 && disp_e.psrc1 == wb.pdst) begin
      disp_e.src1_rdy = 1'b1;
      disp_e.src1_val = wb.data;
    end
    if (disp_e.uinstr.src2_type != OP_REG) begin
      disp_e.src2_rdy = 1'b1;
      disp_e.src2_val = '0;
    end else if (!disp_e.src2_rdy && rs.iprf_wr_en_ex1 && disp_e.psrc2 == wb.pdst) begin
      disp_e.src2_rdy = 1'b1;
      disp_e.src2_val = wb.data;
    end
  end
  // Per-entry wakeup CAMs, allocation into the lowest free slot and release on issue or nuke
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (rs.iprf_wr_en_ex1 && !nuke && !ent_q[i].src1_rdy && ent_q[i].psrc1 == wb.pdst) begin
        ent_d[i].src1_rdy = 1'b1;
        ent_d[i].src1_val = wb.data;
      end
      if (rs.iprf_wr_en_ex1 && !nuke && !ent_q[i].src2_rdy && ent_q[i].psrc2 == wb.pdst) begin
        ent_d[i].src2_rdy = 1'b1;
        ent_d[i].src2_val = wb.data;
      end
      if (alloc[i]) ent_d[i] = disp_e;
      valid_d[i] = !nuke && (alloc[i] || (valid_q[i] && !sel[i]));
    end
  end
  // Issue packet mux from the selected entry
  always_comb begin
    pkt_d = pkt_q;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (sel[i]) pkt_d = '{ent_q[i].uinstr, ent_q[i].robid, ent_q[i].pdst, ent_q[i].src1_val, ent_q[i].src2_val};
  end
  // Entry array, occupancy and issue flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      occ_q <= '0;
      iss_q <= 1'b0;
      pkt_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q <= occ_d;
      iss_q <= |sel;
      pkt_q <= pkt_d;
      for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
    end
  end
  assign rs.disp_rdy_rs0 = disp_rdy;
  assign rs.iss_ex0 = iss_q;
  assign rs.iss_pkt_ex0 = pkt_q;
  assign rs.rs_occ = occ_q;
  a_sel: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(sel));
  a_full: assert property (@(posedge clk) disable iff (!reset_n) !(|alloc) || (disp_rdy && (alloc & valid_q) == '0));
  a_occ: assert property (@(posedge clk) disable iff (!reset_n) 32'(occ_q) == $countones(valid_q));
endmodule

// File: tb/tb_rs_int.sv
// tb_rs_int: directed scenarios and randomized traffic checked against an age-ordered queue model
module tb_rs_int;
  import rs_int_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  rs_int_if bus();
  rs_int dut (.clk(clk), .reset_n(reset_n), .rs(bus));
  int errors = 0;
  int checks = 0;
  typedef struct {
    t_uinstr u;
    logic [ROBID_W-1:0] robid;
    logic [PREG_W-1:0] pdst, ps1, ps2;
    bit r1, r2;
    logic [DATA_W-1:0] v1, v2;
  } m_ent;
  m_ent q[$];
  bit exp_iss, last_acc;
  t_iss_pkt exp_pkt;

  // Model: queue kept oldest-first; one cycle of RS behaviour from the inputs present at the edge
  task automatic model_step();
    int idx;
    m_ent e;
    t_rs_disp_pkt p;
    last_acc = 1'b0;
    if (bus.nuke_rb1.valid) begin
      q.delete();
      exp_iss = 1'b0;
      return;
    end
    last_acc = bus.disp_valid_rs0 && q.size() < NUM_ENTRIES;
    idx = -1;
    foreach (q[k]) if (idx < 0 && q[k].r1 && q[k].r2) idx = k;
    exp_iss = idx >= 0;
    if (exp_iss) begin
      exp_pkt.uinstr = q[idx].u;
      exp_pkt.robid = q[idx].robid;
      exp_pkt.pdst = q[idx].pdst;
      exp_pkt.src1_val = q[idx].v1;
      exp_pkt.src2_val = q[idx].v2;
      q.delete(idx);
    end
    if (bus.iprf_wr_en_ex1)
      foreach (q[k]) begin
        if (!q[k].r1 && q[k].ps1 == bus.iprf_wr_pkt_ex1.pdst) begin q[k].r1 = 1; q[k].v1 = bus.iprf_wr_pkt_ex1.data; end
        if (!q[k].r2 && q[k].ps2 == bus.iprf_wr_pkt_ex1.pdst) begin q[k].r2 = 1; q[k].v2 = bus.iprf_wr_pkt_ex1.data; end
      end
    if (last_acc) begin
      p = bus.disp_pkt_rs0;
      e.u = p.uinstr; e.robid = p.robid; e.pdst = p.pdst; e.ps1 = p.psrc1; e.ps2 = p.psrc2;
      e.r1 = p.src1_rdy; e.v1 = p.src1_val;
      if (!e.r1 && bus.iprf_wr_en_ex1 && p.psrc1 == bus.iprf_wr_pkt_ex1.pdst) begin e.r1 = 1; e.v1 = bus.iprf_wr_pkt_ex1.data; end
      e.r2 = p.src2_rdy; e.v2 = p.src2_val;
      if (p.uinstr.src2_type != OP_REG) begin e.r2 = 1; e.v2 = '0; end
      else if (!e.r2 && bus.iprf_wr_en_ex1 && p.psrc2 == bus.iprf_wr_pkt_ex1.pdst) begin e.r2 = 1; e.v2 = bus.iprf_wr_pkt_ex1.data; end
      q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.disp_valid_rs0 = 1'b0;
    bus.iprf_wr_en_ex1 = 1'b0;
    bus.nuke_rb1.valid = 1'b0;
  endtask

  task automatic set_disp(input logic [ROBID_W-1:0] robid, input logic [PREG_W-1:0] ps1, input bit r1,
                          input logic [DATA_W-1:0] v1, input logic [PREG_W-1:0] ps2, input bit r2,
                          input logic [DATA_W-1:0] v2, input t_optype ot);
    bus.disp_valid_rs0 = 1'b1;
    bus.disp_pkt_rs0.uinstr.opc = 8'(robid) ^ 8'hA5;
    bus.disp_pkt_rs0.uinstr.src2_type = ot;
    bus.disp_pkt_rs0.robid = robid;
    bus.disp_pkt_rs0.pdst = PREG_W'(robid + 1);
    bus.disp_pkt_rs0.psrc1 = ps1;
    bus.disp_pkt_rs0.psrc2 = ps2;
    bus.disp_pkt_rs0.src1_rdy = r1;
    bus.disp_pkt_rs0.src2_rdy = r2;
    bus.disp_pkt_rs0.src1_val = v1;
    bus.disp_pkt_rs0.src2_val = v2;
  endtask

  task automatic wake(input logic [PREG_W-1:0] pd, input logic [DATA_W-1:0] d);
    bus.iprf_wr_en_ex1 = 1'b1;
    bus.iprf_wr_pkt_ex1.pdst = pd;
    bus.iprf_wr_pkt_ex1.data = d;
  endtask

  task automatic test_reset();
    idle();
    bus.disp_pkt_rs0 = '0;
    bus.iprf_wr_pkt_ex1 = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.iss_ex0 !== 1'b0) begin errors++; $display("FAIL reset_iss got=%0b exp=0", bus.iss_ex0); end
    checks++; if (bus.rs_occ !== 4'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", bus.rs_occ); end
    checks++; if (bus.disp_rdy_rs0 !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%0b exp=1", bus.disp_rdy_rs0); end
    checks++; if (bus.iss_pkt_ex0 !== '0) begin errors++; $display("FAIL reset_pkt got=%h exp=0", bus.iss_pkt_ex0); end
    reset_n = 1'b1;
    q.delete();
    exp_iss = 1'b0;
  endtask

  task automatic test_basic();
    set_disp(3, 1, 1, 5, 2, 1, 7, OP_REG);
    cyc();
    idle();
    checks++; if (bus.iss_ex0 !== 1'b0) begin errors++; $display("FAIL basic_n1 got=%0b exp=0", bus.iss_ex0); end
    checks++; if (bus.rs_occ !== 4'd1) begin errors++; $display("FAIL basic_occ got=%0d exp=1", bus.rs_occ); end
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b1 || bus.iss_pkt_ex0.robid !== 6'd3) begin errors++; $display("FAIL basic_n2 got=%0b/%0d exp=1/3", bus.iss_ex0, bus.iss_pkt_ex0.robid); end
    checks++; if (bus.iss_pkt_ex0.src1_val !== 32'd5 || bus.iss_pkt_ex0.src2_val !== 32'd7) begin errors++; $display("FAIL basic_vals got=%0d/%0d exp=5/7", bus.iss_pkt_ex0.src1_val, bus.iss_pkt_ex0.src2_val); end
    set_disp(4, 0, 1, 9, 0, 0, 32'hDEAD, OP_IMM);
    cyc();
    idle();
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b1 || bus.iss_pkt_ex0.robid !== 6'd4 || bus.iss_pkt_ex0.src2_val !== 32'd0) begin errors++; $display("FAIL basic_imm got=%0b/%0d/%h exp=1/4/0", bus.iss_ex0, bus.iss_pkt_ex0.robid, bus.iss_pkt_ex0.src2_val); end
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b0) begin errors++; $display("FAIL basic_bubble got=%0b exp=0", bus.iss_ex0); end
  endtask

  task automatic test_wakeup();
    set_disp(1, 1, 1, 11, 2, 1, 22, OP_REG);
    cyc();
    set_disp(2, 10, 0, 0, 3, 1, 33, OP_REG);
    cyc();
    idle();
    checks++; if (bus.iss_ex0 !== 1'b1 || bus.iss_pkt_ex0.robid !== 6'd1) begin errors++; $display("FAIL wake_prod got=%0b/%0d exp=1/1", bus.iss_ex0, bus.iss_pkt_ex0.robid); end
    wake(10, 32'h42);
    cyc();
    idle();
    checks++; if (bus.iss_ex0 !== 1'b0) begin errors++; $display("FAIL wake_bubble got=%0b exp=0", bus.iss_ex0); end
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b1 || bus.iss_pkt_ex0.robid !== 6'd2 || bus.iss_pkt_ex0.src1_val !== 32'h42) begin errors++; $display("FAIL wake_dep got=%0b/%0d/%h exp=1/2/42", bus.iss_ex0, bus.iss_pkt_ex0.robid, bus.iss_pkt_ex0.src1_val); end
  endtask

  task automatic test_full();
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      set_disp(ROBID_W'(8 + i), PREG_W'(30 + i), 0, 0, 0, 1, 0, OP_REG);
      cyc();
    end
    idle();
    checks++; if (bus.rs_occ !== 4'd8 || bus.disp_rdy_rs0 !== 1'b0) begin errors++; $display("FAIL full_occ got=%0d/%0b exp=8/0", bus.rs_occ, bus.disp_rdy_rs0); end
    set_disp(50, 0, 1, 1, 0, 1, 2, OP_REG);
    wake(33, 77);
    cyc();
    bus.iprf_wr_en_ex1 = 1'b0;
    checks++; if (bus.iss_ex0 !== 1'b0 || bus.rs_occ !== 4'd8 || bus.disp_rdy_rs0 !== 1'b0) begin errors++; $display("FAIL full_hold got=%0b/%0d/%0b exp=0/8/0", bus.iss_ex0, bus.rs_occ, bus.disp_rdy_rs0); end
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b1 || bus.iss_pkt_ex0.robid !== 6'd11 || bus.iss_pkt_ex0.src1_val !== 32'd77) begin errors++; $display("FAIL full_issue got=%0b/%0d/%0d exp=1/11/77", bus.iss_ex0, bus.iss_pkt_ex0.robid, bus.iss_pkt_ex0.src1_val); end
    checks++; if (bus.rs_occ !== 4'd7 || bus.disp_rdy_rs0 !== 1'b1) begin errors++; $display("FAIL full_free got=%0d/%0b exp=7/1", bus.rs_occ, bus.disp_rdy_rs0); end
    cyc();
    idle();
    checks++; if (bus.rs_occ !== 4'd8 || bus.iss_ex0 !== 1'b0) begin errors++; $display("FAIL full_refill got=%0d/%0b exp=8/0", bus.rs_occ, bus.iss_ex0); end
    bus.nuke_rb1.valid = 1'b1;
    cyc();
    idle();
    checks++; if (bus.rs_occ !== 4'd0 || bus.iss_ex0 !== 1'b0) begin errors++; $display("FAIL full_nuke got=%0d/%0b exp=0/0", bus.rs_occ, bus.iss_ex0); end
  endtask

  task automatic test_age();
    for (int i = 0; i < 6; i++) begin
      set_disp(ROBID_W'(20 + i), PREG_W'(30 + i), 0, 0, 0, 1, 0, OP_REG);
      cyc();
    end
    idle();
    wake(32, 1);
    cyc();
    idle();
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b1 || bus.iss_pkt_ex0.robid !== 6'd22) begin errors++; $display("FAIL age_free2 got=%0b/%0d exp=1/22", bus.iss_ex0, bus.iss_pkt_ex0.robid); end
    set_disp(40, 35, 0, 0, 0, 1, 0, OP_REG);
    cyc();
    idle();
    wake(35, 5);
    cyc();
    idle();
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b1 || bus.iss_pkt_ex0.robid !== 6'd25) begin errors++; $display("FAIL age_first got=%0b/%0d exp=1/25", bus.iss_ex0, bus.iss_pkt_ex0.robid); end
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b1 || bus.iss_pkt_ex0.robid !== 6'd40) begin errors++; $display("FAIL age_second got=%0b/%0d exp=1/40", bus.iss_ex0, bus.iss_pkt_ex0.robid); end
    bus.nuke_rb1.valid = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_same_cycle_wakeup();
    set_disp(6, 1, 1, 3, 12, 0, 0, OP_REG);
    wake(12, 32'h1234);
    cyc();
    idle();
    checks++; if (bus.iss_ex0 !== 1'b0) begin errors++; $display("FAIL scw_n1 got=%0b exp=0", bus.iss_ex0); end
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b1 || bus.iss_pkt_ex0.robid !== 6'd6 || bus.iss_pkt_ex0.src2_val !== 32'h1234) begin errors++; $display("FAIL scw_n2 got=%0b/%0d/%h exp=1/6/1234", bus.iss_ex0, bus.iss_pkt_ex0.robid, bus.iss_pkt_ex0.src2_val); end
  endtask

  task automatic test_nuke();
    for (int i = 0; i < 3; i++) begin
      set_disp(ROBID_W'(60 + i), PREG_W'(40 + i), 0, 0, 0, 1, 0, OP_REG);
      cyc();
    end
    set_disp(63, 0, 1, 1, 0, 1, 1, OP_REG);
    cyc();
    idle();
    checks++; if (bus.rs_occ !== 4'd4) begin errors++; $display("FAIL nuke_pre got=%0d exp=4", bus.rs_occ); end
    bus.nuke_rb1.valid = 1'b1;
    wake(40, 9);
    set_disp(1, 0, 1, 1, 0, 1, 1, OP_REG);
    cyc();
    idle();
    checks++; if (bus.iss_ex0 !== 1'b0 || bus.rs_occ !== 4'd0 || bus.disp_rdy_rs0 !== 1'b1) begin errors++; $display("FAIL nuke_n1 got=%0b/%0d/%0b exp=0/0/1", bus.iss_ex0, bus.rs_occ, bus.disp_rdy_rs0); end
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b0 || bus.rs_occ !== 4'd0) begin errors++; $display("FAIL nuke_n2 got=%0b/%0d exp=0/0", bus.iss_ex0, bus.rs_occ); end
  endtask

  task automatic test_async_reset();
    set_disp(7, 0, 1, 1, 0, 1, 2, OP_REG);
    cyc();
    idle();
    cyc();
    checks++; if (bus.iss_ex0 !== 1'b1) begin errors++; $display("FAIL arst_pre got=%0b exp=1", bus.iss_ex0); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.iss_ex0 !== 1'b0 || bus.rs_occ !== 4'd0) begin errors++; $display("FAIL arst_drop got=%0b/%0d exp=0/0", bus.iss_ex0, bus.rs_occ); end
    #1;
    reset_n = 1'b1;
    q.delete();
    exp_iss = 1'b0;
  endtask

  task automatic test_random();
    t_rs_disp_pkt p;
    for (int n = 0; n < 3000; n++) begin
      if (last_acc || !bus.disp_valid_rs0) begin
        p.uinstr.opc = 8'($urandom);
        p.uinstr.src2_type = t_optype'(2'($urandom_range(0, 2)));
        p.robid = ROBID_W'($urandom);
        p.pdst = PREG_W'($urandom_range(0, 15));
        p.psrc1 = PREG_W'($urandom_range(0, 15));
        p.psrc2 = PREG_W'($urandom_range(0, 15));
        p.src1_rdy = $urandom_range(0, 1) == 1;
        p.src2_rdy = $urandom_range(0, 2) == 0;
        p.src1_val = $urandom;
        p.src2_val = $urandom;
        bus.disp_pkt_rs0 = p;
        bus.disp_valid_rs0 = $urandom_range(0, 99) < 60;
      end
      bus.iprf_wr_en_ex1 = $urandom_range(0, 1) == 1;
      bus.iprf_wr_pkt_ex1.pdst = PREG_W'($urandom_range(0, 15));
      bus.iprf_wr_pkt_ex1.data = $urandom;
      bus.nuke_rb1.valid = $urandom_range(0, 63) == 0;
      cyc();
      checks++; if (bus.iss_ex0 !== exp_iss) begin errors++; $display("FAIL rnd_iss cyc=%0d got=%0b exp=%0b", n, bus.iss_ex0, exp_iss); end
      if (exp_iss) begin
        checks++; if (bus.iss_pkt_ex0 !== exp_pkt) begin errors++; $display("FAIL rnd_pkt cyc=%0d got=%h exp=%h", n, bus.iss_pkt_ex0, exp_pkt); end
      end
      checks++; if (32'(bus.rs_occ) !== q.size()) begin errors++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", n, bus.rs_occ, q.size()); end
      checks++; if (bus.disp_rdy_rs0 !== (q.size() < NUM_ENTRIES)) begin errors++; $display("FAIL rnd_rdy cyc=%0d got=%0b exp=%0b", n, bus.disp_rdy_rs0, q.size() < NUM_ENTRIES); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_age();
    test_same_cycle_wakeup();
    test_nuke();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
